// File: rtl/pic_inta_sequencer.sv
// +----------------------------------------------------------------------------+
// | pic_inta_sequencer: 8086-mode INTA# sequencer (freeze, cascade, vector).   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module pic_inta_sequencer #(
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             intan,
    input  logic             irq_req,
    input  logic [2:0]       irq_id,
    input  logic             spen_n,
    input  logic             buf_mode,
    input  logic             ms_cfg,
    input  logic             sngl,
    input  logic [7:0]       icw3,
    input  logic [2:0]       slave_id,
    input  logic [4:0]       vec_base,
    input  logic [2:0]       cas_in,
    output logic             int_out,
    output logic             isr_set,
    output logic [2:0]       isr_idx,
    output logic [2:0]       cas_out,
    output logic             cas_oe,
    output logic [VEC_W-1:0] data_out,
    output logic             data_oe,
    output logic             buf_en_n
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_P1    = 3'd2,
        S_GAP   = 3'd3,
        S_P2    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             int_out_q, int_out_d;
    logic             isr_set_q, isr_set_d;
    logic [2:0]       isr_idx_q, isr_idx_d;
    logic [2:0]       cas_out_q, cas_out_d;
    logic             cas_oe_q, cas_oe_d;
    logic [VEC_W-1:0] data_out_q, data_out_d;
    logic             data_oe_q, data_oe_d;
    logic             buf_en_n_q, buf_en_n_d;

    logic             is_master;
    logic             fall;
    logic             rise;
    logic             cascaded;
    logic [VEC_W-1:0] vec;

    assign is_master = sngl | (buf_mode ? ms_cfg : spen_n);
    assign fall      = s3_q & ~s2_q;
    assign rise      = ~s3_q & s2_q;
    assign cascaded  = is_master & ~sngl & icw3[isr_idx_q];

    always_comb begin
        vec                = '0;
        vec[VEC_W-1 -: 5]  = vec_base;
        vec[2:0]           = isr_idx_q;
    end

    always_comb begin
        state_d    = state_q;
        int_out_d  = int_out_q;
        isr_set_d  = 1'b0;
        isr_idx_d  = isr_idx_q;
        cas_out_d  = cas_out_q;
        cas_oe_d   = cas_oe_q;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;

        case (state_q)
            S_IDLE: begin
                int_out_d = irq_req;
                if (irq_req) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                int_out_d = 1'b1;
                if (fall) begin
                    state_d   = S_P1;
                    int_out_d = 1'b0;
                    // A request that vanished before the first pulse is answered as IR7.
                    isr_idx_d = irq_req ? irq_id : 3'd7;
                    isr_set_d = irq_req;
                    cas_oe_d  = is_master & ~sngl & icw3[isr_idx_d];
                    if (cas_oe_d) begin
                        cas_out_d = isr_idx_d;
                    end
                end
            end
            S_P1: begin
                int_out_d = 1'b0;
                if (rise) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (fall) begin
                    state_d = S_P2;
                    if (is_master ? ~cascaded : (cas_in == slave_id)) begin
                        data_out_d = vec;
                        data_oe_d  = 1'b1;
                    end
                end
            end
            S_P2: begin
                if (rise) begin
                    state_d   = S_IDLE;
                    data_oe_d = 1'b0;
                    cas_oe_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        buf_en_n_d = buf_mode ? ~data_oe_d : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            s3_q       <= 1'b1;
            int_out_q  <= 1'b0;
            isr_set_q  <= 1'b0;
            isr_idx_q  <= 3'd0;
            cas_out_q  <= 3'd0;
            cas_oe_q   <= 1'b0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            buf_en_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            s1_q       <= intan;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            int_out_q  <= int_out_d;
            isr_set_q  <= isr_set_d;
            isr_idx_q  <= isr_idx_d;
            cas_out_q  <= cas_out_d;
            cas_oe_q   <= cas_oe_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            buf_en_n_q <= buf_en_n_d;
        end
    end

    assign int_out  = int_out_q;
    assign isr_set  = isr_set_q;
    assign isr_idx  = isr_idx_q;
    assign cas_out  = cas_out_q;
    assign cas_oe   = cas_oe_q;
    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign buf_en_n = buf_en_n_q;

endmodule

`default_nettype wire

// File: tb/tb_pic_inta_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_pic_inta_sequencer: directed and randomized INTA sequences vs. model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pic_inta_sequencer;

    localparam int VEC_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             intan;
    logic             irq_req;
    logic [2:0]       irq_id;
    logic             spen_n;
    logic             buf_mode;
    logic             ms_cfg;
    logic             sngl;
    logic [7:0]       icw3;
    logic [2:0]       slave_id;
    logic [4:0]       vec_base;
    logic [2:0]       cas_in;
    logic             int_out;
    logic             isr_set;
    logic [2:0]       isr_idx;
    logic [2:0]       cas_out;
    logic             cas_oe;
    logic [VEC_W-1:0] data_out;
    logic             data_oe;
    logic             buf_en_n;

    int checks = 0;
    int errors = 0;

    pic_inta_sequencer #(.VEC_W(VEC_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .intan    (intan),
        .irq_req  (irq_req),
        .irq_id   (irq_id),
        .spen_n   (spen_n),
        .buf_mode (buf_mode),
        .ms_cfg   (ms_cfg),
        .sngl     (sngl),
        .icw3     (icw3),
        .slave_id (slave_id),
        .vec_base (vec_base),
        .cas_in   (cas_in),
        .int_out  (int_out),
        .isr_set  (isr_set),
        .isr_idx  (isr_idx),
        .cas_out  (cas_out),
        .cas_oe   (cas_oe),
        .data_out (data_out),
        .data_oe  (data_oe),
        .buf_en_n (buf_en_n)
    );

    always #5 clk = ~clk;

    // Full two-pulse acknowledge with expectations derived from the configuration.
    task automatic run_inta(input bit spur);
        bit         master, casc, resp;
        logic [2:0] idx;
        logic [7:0] vec;
        master = sngl || (buf_mode ? ms_cfg : spen_n);
        idx    = spur ? 3'd7 : irq_id;
        casc   = master && !sngl && icw3[idx];
        resp   = master ? !casc : (cas_in == slave_id);
        vec    = {vec_base, idx};

        @(negedge clk);
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL int_idle: got %b want 0", int_out); end
        irq_req = 1'b1;
        @(negedge clk);
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL int_armed: got %b want 1", int_out); end
        if (spur) begin
            irq_req = 1'b0;
            @(negedge clk);
            checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL int_hold_spur: got %b want 1", int_out); end
        end

        intan = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (isr_set !== 1'b0 || int_out !== 1'b1) begin errors++; $display("FAIL p1_early: isr_set=%b int_out=%b want 0/1", isr_set, int_out); end
        @(negedge clk);
        checks++; if (isr_set !== !spur) begin errors++; $display("FAIL isr_set_p1: got %b want %b", isr_set, !spur); end
        checks++; if (isr_idx !== idx) begin errors++; $display("FAIL isr_idx: got %0d want %0d", isr_idx, idx); end
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL int_p1: got %b want 0", int_out); end
        checks++; if (cas_oe !== casc) begin errors++; $display("FAIL cas_oe_p1: got %b want %b", cas_oe, casc); end
        if (casc) begin
            checks++; if (cas_out !== idx) begin errors++; $display("FAIL cas_out_p1: got %0d want %0d", cas_out, idx); end
        end
        irq_req = 1'b0;
        @(negedge clk);
        checks++; if (isr_set !== 1'b0) begin errors++; $display("FAIL isr_set_width: got %b want 0", isr_set); end
        @(negedge clk);

        intan = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (cas_oe !== casc || data_oe !== 1'b0) begin errors++; $display("FAIL gap: cas_oe=%b data_oe=%b want %b/0", cas_oe, data_oe, casc); end

        intan = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL p2_early: data_oe=%b want 0", data_oe); end
        @(negedge clk);
        checks++; if (data_oe !== resp) begin errors++; $display("FAIL data_oe_p2: got %b want %b", data_oe, resp); end
        if (resp) begin
            checks++; if (data_out !== vec) begin errors++; $display("FAIL data_out_p2: got %02h want %02h", data_out, vec); end
        end
        checks++; if (cas_oe !== casc) begin errors++; $display("FAIL cas_oe_p2: got %b want %b", cas_oe, casc); end
        checks++; if (buf_en_n !== (buf_mode ? !resp : 1'b1)) begin errors++; $display("FAIL buf_en_n_p2: got %b want %b", buf_en_n, buf_mode ? !resp : 1'b1); end
        @(negedge clk);

        intan = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (data_oe !== resp || cas_oe !== casc) begin errors++; $display("FAIL p2_hold: data_oe=%b cas_oe=%b want %b/%b", data_oe, cas_oe, resp, casc); end
        @(negedge clk);
        checks++; if (data_oe !== 1'b0 || cas_oe !== 1'b0 || buf_en_n !== 1'b1 || int_out !== 1'b0) begin
            errors++; $display("FAIL p2_exit: data_oe=%b cas_oe=%b buf_en_n=%b int_out=%b want 0/0/1/0", data_oe, cas_oe, buf_en_n, int_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        intan    = 1'b1;
        irq_req  = 1'b1;
        irq_id   = 3'd5;
        spen_n   = 1'b1;
        buf_mode = 1'b1;
        ms_cfg   = 1'b1;
        sngl     = 1'b0;
        icw3     = 8'hFF;
        slave_id = 3'd0;
        vec_base = 5'h1F;
        cas_in   = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if ({int_out, isr_set, isr_idx, cas_out, cas_oe, data_out, data_oe, buf_en_n} !== {1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_values: int=%b set=%b idx=%0d cas=%0d cas_oe=%b data=%02h data_oe=%b buf_en_n=%b", int_out, isr_set, isr_idx, cas_out, cas_oe, data_out, data_oe, buf_en_n);
        end
        irq_req = 1'b0;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_master();
        sngl = 1'b1; buf_mode = 1'b0; spen_n = 1'b0; icw3 = 8'hFF;
        vec_base = 5'h08; irq_id = 3'd3;
        run_inta(1'b0);
    endtask

    task automatic test_cascade_master();
        sngl = 1'b0; buf_mode = 1'b0; spen_n = 1'b1; icw3 = 8'h04;
        vec_base = 5'h08; irq_id = 3'd2;
        run_inta(1'b0);
    endtask

    task automatic test_slave();
        sngl = 1'b0; buf_mode = 1'b0; spen_n = 1'b0; icw3 = 8'h00;
        slave_id = 3'd2; vec_base = 5'h10; irq_id = 3'd5;
        cas_in = 3'd2;
        run_inta(1'b0);
        cas_in = 3'd3;
        run_inta(1'b0);
    endtask

    task automatic test_spurious();
        sngl = 1'b1; buf_mode = 1'b0; spen_n = 1'b1;
        vec_base = 5'h15; irq_id = 3'd1;
        run_inta(1'b1);
    endtask

    task automatic test_buffered();
        sngl = 1'b0; buf_mode = 1'b1; ms_cfg = 1'b1; spen_n = 1'b0;
        icw3 = 8'h00; vec_base = 5'h0A; irq_id = 3'd6;
        run_inta(1'b0);
    endtask

    task automatic test_reset_in_gap();
        sngl = 1'b0; buf_mode = 1'b0; spen_n = 1'b1; icw3 = 8'h40;
        vec_base = 5'h1B; irq_id = 3'd6;
        @(negedge clk);
        irq_req = 1'b1;
        @(negedge clk);
        intan = 1'b0;
        repeat (4) @(negedge clk);
        irq_req = 1'b0;
        intan   = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (cas_oe !== 1'b1 || cas_out !== 3'd6) begin errors++; $display("FAIL gap_before_reset: cas_oe=%b cas_out=%0d want 1/6", cas_oe, cas_out); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({int_out, isr_set, isr_idx, cas_out, cas_oe, data_out, data_oe, buf_en_n} !== {1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_in_gap: int=%b set=%b idx=%0d cas=%0d cas_oe=%b data=%02h data_oe=%b buf_en_n=%b", int_out, isr_set, isr_idx, cas_out, cas_oe, data_out, data_oe, buf_en_n);
        end
        rst_n = 1'b1;
        @(negedge clk);
        intan = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 6) intan = 1'b1;
            @(negedge clk);
            checks++; if (int_out !== 1'b0 || isr_set !== 1'b0 || cas_oe !== 1'b0 || data_oe !== 1'b0) begin
                errors++; $display("FAIL quiet_after_reset[%0d]: int=%b set=%b cas_oe=%b data_oe=%b want all 0", i, int_out, isr_set, cas_oe, data_oe);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            sngl     = ($urandom_range(0, 3) == 0);
            buf_mode = $urandom_range(0, 1);
            ms_cfg   = $urandom_range(0, 1);
            spen_n   = $urandom_range(0, 1);
            icw3     = 8'($urandom);
            irq_id   = 3'($urandom);
            slave_id = 3'($urandom);
            vec_base = 5'($urandom);
            cas_in   = $urandom_range(0, 1) ? slave_id : 3'($urandom);
            run_inta($urandom_range(0, 4) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_cascade_master();
        test_slave();
        test_spurious();
        test_buffered();
        test_reset_in_gap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
